// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, feeds decode through a 2-entry buffer,
// and shares the memory port with a program loader. Define FETCH_PERF_EN for perf counters.
module fetch_sequencer #(
  parameter int          ADDR_W   = 5,
  parameter int          DATA_W   = 64,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_update,
  input  logic [31:0]       pc_new,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [31:0]       inst_pc,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_gnt
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [31:0]       pc, pc_nxt;
  logic [1:0]        count, count_nxt;
  logic              inflight, inflight_nxt;
  logic [31:0]       inflight_pc, inflight_pc_nxt;
  logic [DATA_W-1:0] e0_data, e0_data_nxt, e1_data, e1_data_nxt;
  logic [31:0]       e0_pc, e0_pc_nxt, e1_pc, e1_pc_nxt;

  logic       pop;
  logic       push;
  logic       credit;
  logic [2:0] occupancy;

  assign inst_valid = (count != 2'd0);
  assign inst       = e0_data;
  assign inst_pc    = e0_pc;
  assign pop        = inst_valid & inst_ready;

  // A read returning during a redirect belongs to the old stream and is dropped.
  assign push      = inflight & ~pc_update;
  assign occupancy = {1'b0, count} + {2'b00, inflight};
  assign credit    = occupancy < (3'd2 + {2'b00, pop});

  assign mem_re = ~reset & (state == RUN) & ~pc_update & ~ld_req & credit;
  assign mem_we = ~reset & (state == LOAD) & ld_req;
  assign ld_gnt = mem_we;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_we) begin
      mem_addr  = ld_addr;
      mem_wdata = ld_data;
    end else if (mem_re) begin
      mem_addr  = pc[ADDR_W-1:0];
    end
  end

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    count_nxt       = count;
    inflight_nxt    = mem_re;
    inflight_pc_nxt = inflight_pc;
    e0_data_nxt     = e0_data;
    e0_pc_nxt       = e0_pc;
    e1_data_nxt     = e1_data;
    e1_pc_nxt       = e1_pc;

    if (mem_re) begin
      pc_nxt          = pc + 32'd1;
      inflight_pc_nxt = pc;
    end

    if (push && pop) begin
      if (count == 2'd2) begin
        e0_data_nxt = e1_data;
        e0_pc_nxt   = e1_pc;
        e1_data_nxt = mem_rdata;
        e1_pc_nxt   = inflight_pc;
      end else begin
        e0_data_nxt = mem_rdata;
        e0_pc_nxt   = inflight_pc;
      end
    end else if (push && (count != 2'd2)) begin
      if (count == 2'd0) begin
        e0_data_nxt = mem_rdata;
        e0_pc_nxt   = inflight_pc;
      end else begin
        e1_data_nxt = mem_rdata;
        e1_pc_nxt   = inflight_pc;
      end
      count_nxt = count + 2'd1;
    end else if (pop) begin
      e0_data_nxt = e1_data;
      e0_pc_nxt   = e1_pc;
      count_nxt   = count - 2'd1;
    end

    case (state)
      RUN: begin
        if (pc_update) begin
          count_nxt = 2'd0;
          pc_nxt    = pc_new;
        end else if (ld_req) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (pc_update) begin
          count_nxt = 2'd0;
          pc_nxt    = pc_new;
        end
        if (!inflight) begin
          state_nxt = LOAD;
          count_nxt = 2'd0;
          // Rewind to the oldest undelivered entry (after any pop this cycle).
          if (!pc_update) begin
            if (count == 2'd2) begin
              pc_nxt = pop ? e1_pc : e0_pc;
            end else if ((count == 2'd1) && !pop) begin
              pc_nxt = e0_pc;
            end
          end
        end
      end
      LOAD: begin
        if (pc_update) begin
          pc_nxt = pc_new;
        end
        if (!ld_req) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      count       <= 2'd0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      e0_data     <= '0;
      e0_pc       <= '0;
      e1_data     <= '0;
      e1_pc       <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      count       <= count_nxt;
      inflight    <= inflight_nxt;
      inflight_pc <= inflight_pc_nxt;
      e0_data     <= e0_data_nxt;
      e0_pc       <= e0_pc_nxt;
      e1_data     <= e1_data_nxt;
      e1_pc       <= e1_pc_nxt;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (pop && (perf_fetched != '1)) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (inst_valid && !inst_ready && (perf_stall != '1)) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: cycle table for streaming/backpressure/redirect,
// then hand sequences for loader arbitration, redirect+load and mid-operation reset.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pc_update = 1'b0;
  logic [31:0] pc_new = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [63:0] inst;
  logic [31:0] inst_pc;
  logic        mem_re;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic        ld_req = 1'b0;
  logic [4:0]  ld_addr = '0;
  logic [63:0] ld_data = '0;
  logic        ld_gnt;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  fetch_sequencer #(
    .ADDR_W  (5),
    .DATA_W  (64),
    .RESET_PC(32'd0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pc_update (pc_update),
    .pc_new    (pc_new),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst      (inst),
    .inst_pc   (inst_pc),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .ld_req    (ld_req),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_gnt    (ld_gnt)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stall  (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  logic [63:0] mem  [32];
  logic [63:0] gold [32];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  int n_pass = 0;
  int n_tot = 0;
  int overlap = 0;

  always begin
    @(negedge clk);
    #2;
    if (mem_re && mem_we) overlap++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] ld_val(input int a);
    return 64'hBEEF_0000_0000_0000 | 64'(a);
  endfunction

  task automatic check_reset_outputs(input string p);
    chk({p, "_valid"}, 64'(inst_valid), 64'd0);
    chk({p, "_inst_pc"}, 64'(inst_pc), 64'd0);
    chk({p, "_inst"}, inst, 64'd0);
    chk({p, "_mem_re"}, 64'(mem_re), 64'd0);
    chk({p, "_mem_we"}, 64'(mem_we), 64'd0);
    chk({p, "_ld_gnt"}, 64'(ld_gnt), 64'd0);
    chk({p, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({p, "_mem_wdata"}, mem_wdata, 64'd0);
  endtask

  // Hold inst_ready high and check n consecutive deliveries starting at start_pc.
  task automatic collect(input string p, input int n, input logic [31:0] start_pc);
    logic [31:0] e;
    int got;
    e = start_pc;
    got = 0;
    for (int k = 0; k < 20 && got < n; k++) begin
      @(negedge clk);
      inst_ready = 1'b1;
      #1;
      if (inst_valid) begin
        chk($sformatf("%s_pc%0d", p, got), 64'(inst_pc), 64'(e));
        chk($sformatf("%s_inst%0d", p, got), inst, gold[e[4:0]]);
        e = e + 32'd1;
        got++;
      end
    end
    chk({p, "_count"}, 64'(got), 64'(n));
  endtask

  typedef struct {
    logic        rst;
    logic        upd;
    logic [31:0] npc;
    logic        rdy;
    logic        chk_on;
    logic        v;
    logic [31:0] ipc;
    logic        re;
    logic [4:0]  addr;
  } vec_t;

  vec_t tbl [20];
  int   writes;
  int   lat;
  int   re_in_load;
  logic seen;

  initial begin
    for (int i = 0; i < 32; i++) begin
      gold[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
      mem[i]  = gold[i];
    end

    //          rst   upd   npc     rdy   chk   v     ipc     re    addr
    tbl[0]  = '{1'b1, 1'b0, 32'd0,  1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 5'd0};
    tbl[1]  = '{1'b1, 1'b0, 32'd0,  1'b0, 1'b1, 1'b0, 32'd0,  1'b0, 5'd0};
    tbl[2]  = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 32'd0,  1'b1, 5'd0};
    tbl[3]  = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 32'd0,  1'b1, 5'd1};
    tbl[4]  = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 32'd0,  1'b1, 5'd2};
    tbl[5]  = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 32'd1,  1'b1, 5'd3};
    tbl[6]  = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 32'd2,  1'b1, 5'd4};
    tbl[7]  = '{1'b0, 1'b0, 32'd0,  1'b0, 1'b1, 1'b1, 32'd3,  1'b0, 5'd0};
    tbl[8]  = '{1'b0, 1'b0, 32'd0,  1'b0, 1'b1, 1'b1, 32'd3,  1'b0, 5'd0};
    tbl[9]  = '{1'b0, 1'b0, 32'd0,  1'b0, 1'b1, 1'b1, 32'd3,  1'b0, 5'd0};
    tbl[10] = '{1'b0, 1'b0, 32'd0,  1'b0, 1'b1, 1'b1, 32'd3,  1'b0, 5'd0};
    tbl[11] = '{1'b0, 1'b0, 32'd0,  1'b0, 1'b1, 1'b1, 32'd3,  1'b0, 5'd0};
    tbl[12] = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 32'd3,  1'b1, 5'd5};
    tbl[13] = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 32'd4,  1'b1, 5'd6};
    tbl[14] = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 32'd5,  1'b1, 5'd7};
    tbl[15] = '{1'b0, 1'b0, 32'd0,  1'b0, 1'b1, 1'b1, 32'd6,  1'b0, 5'd0};
    tbl[16] = '{1'b0, 1'b1, 32'd20, 1'b0, 1'b1, 1'b1, 32'd6,  1'b0, 5'd0};
    tbl[17] = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 32'd0,  1'b1, 5'd20};
    tbl[18] = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 32'd0,  1'b1, 5'd21};
    tbl[19] = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 32'd20, 1'b1, 5'd22};

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      reset      = tbl[i].rst;
      pc_update  = tbl[i].upd;
      pc_new     = tbl[i].npc;
      inst_ready = tbl[i].rdy;
      #1;
      if (tbl[i].chk_on) begin
        if (tbl[i].rst) begin
          check_reset_outputs($sformatf("v%0d_reset", i));
        end else begin
          chk($sformatf("v%0d_valid", i), 64'(inst_valid), 64'(tbl[i].v));
          if (tbl[i].v) begin
            chk($sformatf("v%0d_inst_pc", i), 64'(inst_pc), 64'(tbl[i].ipc));
            chk($sformatf("v%0d_inst", i), inst, gold[tbl[i].ipc[4:0]]);
          end
          chk($sformatf("v%0d_mem_re", i), 64'(mem_re), 64'(tbl[i].re));
          if (tbl[i].re) chk($sformatf("v%0d_mem_addr", i), 64'(mem_addr), 64'(tbl[i].addr));
          chk($sformatf("v%0d_mem_we", i), 64'(mem_we), 64'd0);
        end
      end
    end
    pc_update = 1'b0;

    // Loader writes 10..12 while pc 8 and 9 are buffered under backpressure.
    @(negedge clk);
    inst_ready = 1'b0;
    pc_update  = 1'b1;
    pc_new     = 32'd8;
    @(negedge clk);
    pc_update  = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      #1;
      seen = inst_valid;
    end
    chk("ld_head_valid", 64'(seen), 64'd1);
    chk("ld_head_pc", 64'(inst_pc), 64'd8);

    @(negedge clk);
    ld_req     = 1'b1;
    writes     = 0;
    lat        = -1;
    re_in_load = 0;
    for (int k = 0; k < 10 && writes < 3; k++) begin
      if (k > 0) @(negedge clk);
      ld_addr = 5'(10 + writes);
      ld_data = ld_val(10 + writes);
      #1;
      if (mem_re) re_in_load++;
      if (ld_gnt) begin
        if (lat < 0) lat = k;
        chk($sformatf("ld_we%0d", writes), 64'(mem_we), 64'd1);
        chk($sformatf("ld_addr%0d", writes), 64'(mem_addr), 64'(10 + writes));
        chk($sformatf("ld_wdata%0d", writes), mem_wdata, ld_val(10 + writes));
        gold[10 + writes] = ld_val(10 + writes);
        writes++;
      end
    end
    chk("ld_writes", 64'(writes), 64'd3);
    chk("ld_first_gnt_latency_1to2", 64'((lat >= 1) && (lat <= 2)), 64'd1);
    chk("ld_no_read_during_load", 64'(re_in_load), 64'd0);
    @(negedge clk);
    ld_req = 1'b0;
    #1;
    chk("ld_drop_gnt", 64'(ld_gnt), 64'd0);
    chk("ld_drop_re", 64'(mem_re), 64'd0);
    @(negedge clk);
    #1;
    chk("ld_resume_re", 64'(mem_re), 64'd1);
    chk("ld_resume_addr", 64'(mem_addr), 64'd8);
    collect("ld_stream", 6, 32'd8);

    // Redirect and loader request in the same cycle: redirect first, then LOAD.
    @(negedge clk);
    inst_ready = 1'b0;
    pc_update  = 1'b1;
    pc_new     = 32'd31;
    ld_req     = 1'b1;
    ld_addr    = 5'd3;
    ld_data    = ld_val(3);
    #1;
    chk("rl_redirect_no_re", 64'(mem_re), 64'd0);
    chk("rl_redirect_no_gnt", 64'(ld_gnt), 64'd0);
    @(negedge clk);
    pc_update = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (mem_re) re_in_load++;
      seen = ld_gnt;
    end
    chk("rl_gnt_seen", 64'(seen), 64'd1);
    chk("rl_flushed", 64'(inst_valid), 64'd0);
    chk("rl_no_read", 64'(re_in_load), 64'd0);
    gold[3] = ld_val(3);
    @(negedge clk);
    ld_req = 1'b0;
    collect("rl_wrap", 4, 32'd31);

    // Reset in the middle of streaming.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_reset_outputs("rst_stream");
    @(negedge clk);
    reset = 1'b0;
    inst_ready = 1'b1;
    #1;
    chk("rst_stream_re", 64'(mem_re), 64'd1);
    chk("rst_stream_addr", 64'(mem_addr), 64'd0);
    @(negedge clk);
    #1;
    chk("rst_stream_lat_v0", 64'(inst_valid), 64'd0);
    @(negedge clk);
    #1;
    chk("rst_stream_lat_v1", 64'(inst_valid), 64'd1);
    chk("rst_stream_pc", 64'(inst_pc), 64'd0);
    chk("rst_stream_inst", inst, gold[0]);

    // Reset in the middle of LOAD, with the loader still requesting.
    @(negedge clk);
    inst_ready = 1'b0;
    ld_req     = 1'b1;
    ld_addr    = 5'd7;
    ld_data    = ld_val(7);
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      seen = ld_gnt;
    end
    chk("rl2_gnt_seen", 64'(seen), 64'd1);
    gold[7] = ld_val(7);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_reset_outputs("rst_load");
    @(negedge clk);
    reset  = 1'b0;
    ld_req = 1'b0;
    #1;
    chk("rst_load_re", 64'(mem_re), 64'd1);
    chk("rst_load_addr", 64'(mem_addr), 64'd0);
    collect("rst_load_stream", 8, 32'd0);

    chk("no_re_we_overlap", 64'(overlap), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
